// File: rtl/lcg_multi.sv
// Multi-lane LCG with per-lane seeding, start/stop control and a valid/ready output stream.
// Define LCG_TEMPER_EN to pass each new lane state through xorshift+rotate tempering before output.
module lcg_multi #(
  parameter int unsigned  WIDTH        = 128,
  parameter int unsigned  LANES        = 2,
  parameter logic [127:0] MULT         = 128'hF0451B9CE7D248FA119D3C2B5AB76403,
  parameter logic [127:0] INC          = 128'h9876DE42A3B150CFA2D9E7B43C1F88B1,
  parameter logic [127:0] DEFAULT_SEED = 128'h0
) (
  input  logic                                        clk,
  input  logic                                        rst,
  input  logic                                        seed_we,
  input  logic [((LANES > 1) ? $clog2(LANES) : 1)-1:0] seed_lane,
  input  logic [WIDTH-1:0]                            seed_data,
  output logic                                        seed_ack,
  output logic                                        seed_err,
  input  logic                                        start,
  input  logic                                        stop,
  output logic                                        running,
  output logic                                        out_valid,
  input  logic                                        out_ready,
  output logic [WIDTH*LANES-1:0]                      out_data,
  output logic [31:0]                                 word_cnt
);

  localparam int unsigned LW = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int unsigned RW = $clog2(WIDTH);

  localparam logic [WIDTH-1:0] MULT_W = WIDTH'(MULT);
  localparam logic [WIDTH-1:0] INC_W  = WIDTH'(INC);
  localparam logic [WIDTH-1:0] SEED_W = WIDTH'(DEFAULT_SEED);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  logic [1:0]                   state;
  logic [1:0]                   state_next;
  logic [LANES-1:0][WIDTH-1:0]  lane_q;
  logic [LANES-1:0][WIDTH-1:0]  lane_next;
  logic [LANES-1:0][WIDTH-1:0]  out_next;
  logic                         advance;
  logic                         accept;
  logic                         seed_ok;

  function automatic logic [WIDTH-1:0] temper(input logic [WIDTH-1:0] s);
`ifdef LCG_TEMPER_EN
    logic [WIDTH-1:0]   x;
    logic [2*WIDTH-1:0] dbl;
    int unsigned        amt;
    x   = s ^ (s >> (WIDTH / 2));
    amt = 32'(s[WIDTH-1 -: RW]) % WIDTH;
    dbl = {x, x} >> amt;
    return dbl[WIDTH-1:0];
`else
    return s;
`endif
  endfunction

  assign advance = (state == S_RUN) && !stop && (!out_valid || out_ready);
  assign accept  = out_valid && out_ready;
  assign seed_ok = seed_we && (state == S_IDLE) && (32'(seed_lane) < LANES);
  assign running = (state == S_RUN);

  always_comb begin
    lane_next = '0;
    out_next  = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      lane_next[i] = lane_q[i] * MULT_W + INC_W + WIDTH'(2 * i);
      out_next[i]  = temper(lane_next[i]);
    end
  end

  // stop always beats start; DRAIN only exits to IDLE once the held word is taken
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: begin
        if (start && !stop) state_next = S_RUN;
      end
      S_RUN: begin
        if (stop) state_next = (out_valid && !out_ready) ? S_DRAIN : S_IDLE;
      end
      S_DRAIN: begin
        if (start && !stop) state_next = S_RUN;
        else if (accept)    state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      out_valid <= 1'b0;
      out_data  <= '0;
      word_cnt  <= '0;
      seed_ack  <= 1'b0;
      seed_err  <= 1'b0;
      for (int unsigned i = 0; i < LANES; i++) begin
        lane_q[i] <= SEED_W + WIDTH'(i);
      end
    end else begin
      state    <= state_next;
      seed_ack <= seed_ok;
      seed_err <= seed_we && !seed_ok;
      if (accept) word_cnt <= word_cnt + 32'd1;
      if (advance) begin
        lane_q    <= lane_next;
        out_data  <= out_next;
        out_valid <= 1'b1;
      end else begin
        if (accept) out_valid <= 1'b0;
        // seed_ok implies IDLE, so a seed write can never collide with an advance
        for (int unsigned i = 0; i < LANES; i++) begin
          if (seed_ok && (seed_lane == LW'(i))) lane_q[i] <= seed_data;
        end
      end
    end
  end

endmodule
